fan_duty_sequencer: RTL
=======================

# fan_duty_sequencer

Sequences the fan PWM datapath: accepts a 4-bit fan-speed target, applies a kick-start burst when spinning up from standstill, then ramps the duty command toward the target one step per PWM period. Drives the duty, minimum-duty and period configuration inputs of the PWM generator and runs from the same prescaled clock enable, so every command change lands on a PWM period boundary.

## Interface
- COUNTER_BITWIDTH, 8, PWM counter width W; period is W+1 bits.
- DUTY_STEP, 17, duty counts per target LSB; DUTY_STEP*15 ≤ 2^W−1 required.
- RAMP_STEP, 4, duty change per PWM period in RAMP; ≥1.
- KICK_PERIODS, 16, PWM periods at full duty during kick-start; 1..255.

- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- clk_en_i  in  1  prescaler enable, identical to the one feeding the PWM generator.
- target_i  in  4  requested speed 0..15.
- target_valid_i  in  1  one-cycle strobe; samples target_i.
- period_i  in  W+1  requested PWM period (counter terminal value).
- min_i  in  W  minimum-duty offset while fan runs.
- duty_o  out  W  duty command to PWM generator.
- min_o  out  W  min-duty command; 0 whenever duty_o==0.
- period_o  out  W+1  period command.
- kick_o  out  1  high while in KICK.
- busy_o  out  1  high in KICK or RAMP.

## Operation
- Target register tgt (4b) loads target_i on target_valid_i, any cycle. Duty goal goal = tgt*DUTY_STEP (W bits, no overflow by parameter rule).
- Period tick: internal counter pc (W+1b) advances on clk_en_i; when clk_en_i && pc==per_l, pc←0, per_l←period_i, tick asserted for that cycle. Mirrors the PWM generator's wrap exactly.
- All state and outputs update only on tick; period_o←period_i on every tick.
- States: IDLE, KICK, RAMP, HOLD.
  - IDLE (duty_o=0, min_o=0): on tick with goal≠0 → KICK, duty_o←2^W−1, kick count kc←KICK_PERIODS−1.
  - KICK: on tick, goal==0 → IDLE, duty_o←0; else kc==0 → HOLD, duty_o←goal; else kc−1.
  - HOLD: on tick, goal≠duty_o → RAMP and perform one ramp step same tick; else stay.
  - RAMP: on tick, duty_o moves toward goal by RAMP_STEP, saturating exactly at goal (no overshoot, no wrap below 0 or above 2^W−1). Reaching goal: goal==0 → IDLE, else → HOLD.
- min_o = min_i registered on tick when next duty_o≠0, else 0 (a stopped fan must see zero output).
- Kick only from IDLE; a RAMP down to nonzero goal never kicks.

## Timing
- Reset: all outputs 0, kick_o=0, busy_o=0, state IDLE, tgt=0, pc=0, per_l=0.
- target_valid_i to command: takes effect at first tick strictly after the strobe cycle; strobe coincident with tick is not seen by that tick.
- Outputs change the cycle after tick; PWM generator samples them at its next wrap, so command-to-pin latency is one PWM period.
- per_l=0 gives a tick on every clk_en_i.
- clk_en_i low: no state change.
- Reset mid-operation: immediate return to reset values; period resumes from pc=0.
- Up-ramp 0→goal (without kick, from HOLD) takes ceil(Δ/RAMP_STEP) ticks.

## Structure
- Shared package: state enumeration (IDLE, KICK, RAMP, HOLD), default parameter constants, goal width helper.
- One sub-module: pwm_period_tick (pc/per_l counter, tick output), reusable by any block aligned to PWM periods.
- Sequencer FSM, saturating ramp arithmetic and output registers in top level.

## Test plan
- Reset, period_i=9, target 0: all outputs 0 indefinitely; period_o=9 after first tick.
- From IDLE, strobe target 10 (goal 170), KICK_PERIODS=16: duty_o=255 for 16 ticks with kick_o=1, then 170, HOLD, busy_o=0.
- HOLD at 170, strobe target 3 (goal 51): duty 166,162,…,54,51 one per tick, last step saturates; then HOLD.
- HOLD at 51, min_i=20, strobe target 0: ramp to 0, min_o drops to 0 on same tick duty_o reaches 0, state IDLE.
- Strobe target 0 during KICK: next tick duty_o=0, kick_o=0, IDLE.
- Strobe coincident with tick: ignored by that tick, applied on following tick; assert rst_i mid-RAMP: outputs 0 immediately.

Source files
------------

// File: rtl/fan_duty_sequencer_pkg.sv
// Shared types and defaults for the fan duty sequencer and its period tick helper.
package fan_duty_sequencer_pkg;

  localparam int unsigned DEF_COUNTER_BITWIDTH = 8;
  localparam int unsigned DEF_DUTY_STEP        = 17;
  localparam int unsigned DEF_RAMP_STEP        = 4;
  localparam int unsigned DEF_KICK_PERIODS     = 16;
  localparam int unsigned TARGET_W             = 4;
  localparam int unsigned KICK_CNT_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KICK,
    ST_RAMP,
    ST_HOLD
  } seq_state_e;

  // Duty goal for a speed target; callers truncate to the counter width.
  function automatic int unsigned goal_of(input logic [TARGET_W-1:0] tgt,
                                          input int unsigned         step);
    return 32'(tgt) * step;
  endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// Tracks the PWM counter wrap so period-aligned logic can act on the same boundary.
module pwm_period_tick #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clk_en_i,
  input  logic [W:0]   period_i,
  output logic         tick_c_o
);

  logic [W:0] pc_q;
  logic [W:0] per_q;

  assign tick_c_o = clk_en_i && (pc_q == per_q);

  // Period is latched at each wrap, matching the PWM generator.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q  <= '0;
      per_q <= '0;
    end else if (clk_en_i) begin
      if (pc_q == per_q) begin
        pc_q  <= '0;
        per_q <= period_i;
      end else begin
        pc_q  <= pc_q + (W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fan_duty_sequencer.sv
// Fan duty sequencer: kick-start from standstill, then ramps duty toward the target once per PWM period.
module fan_duty_sequencer
  import fan_duty_sequencer_pkg::*;
#(
  parameter int unsigned COUNTER_BITWIDTH = DEF_COUNTER_BITWIDTH,
  parameter int unsigned DUTY_STEP        = DEF_DUTY_STEP,
  parameter int unsigned RAMP_STEP        = DEF_RAMP_STEP,
  parameter int unsigned KICK_PERIODS     = DEF_KICK_PERIODS
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clk_en_i,
  input  logic [TARGET_W-1:0]         target_i,
  input  logic                        target_valid_i,
  input  logic [COUNTER_BITWIDTH:0]   period_i,
  input  logic [COUNTER_BITWIDTH-1:0] min_i,
  output logic [COUNTER_BITWIDTH-1:0] duty_o,
  output logic [COUNTER_BITWIDTH-1:0] min_o,
  output logic [COUNTER_BITWIDTH:0]   period_o,
  output logic                        kick_o,
  output logic                        busy_o
);

  localparam int unsigned W = COUNTER_BITWIDTH;
  localparam logic [W-1:0]          DUTY_MAX  = {W{1'b1}};
  localparam logic [W-1:0]          STEP      = W'(RAMP_STEP);
  localparam logic [KICK_CNT_W-1:0] KICK_INIT = KICK_CNT_W'(KICK_PERIODS - 1);

  logic tick_c;

  pwm_period_tick #(.W(W)) u_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clk_en_i (clk_en_i),
    .period_i (period_i),
    .tick_c_o (tick_c)
  );

  seq_state_e            state_q, state_d;
  logic [TARGET_W-1:0]   tgt_q;
  logic [KICK_CNT_W-1:0] kc_q, kc_d;
  logic [W-1:0]          duty_q, duty_d;
  logic [W-1:0]          min_q, min_d;
  logic [W:0]            period_q;
  logic                  kick_q, kick_d;
  logic                  busy_q, busy_d;
  logic [W-1:0]          goal_c;
  logic [W-1:0]          ramp_c;

  assign goal_c = W'(goal_of(tgt_q, DUTY_STEP));

  // One saturating step toward the goal; differences are taken in the safe direction only.
  always_comb begin
    ramp_c = goal_c;
    if (duty_q < goal_c) begin
      if ((goal_c - duty_q) > STEP) ramp_c = duty_q + STEP;
    end else if ((duty_q - goal_c) > STEP) begin
      ramp_c = duty_q - STEP;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    kc_d    = kc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (goal_c != '0) begin
          state_d = ST_KICK;
          duty_d  = DUTY_MAX;
          kc_d    = KICK_INIT;
        end
      end
      ST_KICK: begin
        if (goal_c == '0) begin
          state_d = ST_IDLE;
          duty_d  = '0;
        end else if (kc_q == '0) begin
          state_d = ST_HOLD;
          duty_d  = goal_c;
        end else begin
          kc_d = kc_q - KICK_CNT_W'(1);
        end
      end
      ST_HOLD, ST_RAMP: begin
        duty_d = ramp_c;
        if (ramp_c == goal_c) state_d = (goal_c == '0) ? ST_IDLE : ST_HOLD;
        else                  state_d = ST_RAMP;
      end
      default: state_d = ST_IDLE;
    endcase
    min_d  = (duty_d != '0) ? min_i : '0;
    kick_d = (state_d == ST_KICK);
    busy_d = (state_d == ST_KICK) || (state_d == ST_RAMP);
  end

  // Target is captured any cycle; everything else advances only on the period tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      tgt_q    <= '0;
      kc_q     <= '0;
      duty_q   <= '0;
      min_q    <= '0;
      period_q <= '0;
      kick_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (target_valid_i) tgt_q <= target_i;
      if (tick_c) begin
        state_q  <= state_d;
        kc_q     <= kc_d;
        duty_q   <= duty_d;
        min_q    <= min_d;
        period_q <= period_i;
        kick_q   <= kick_d;
        busy_q   <= busy_d;
      end
    end
  end

  assign duty_o   = duty_q;
  assign min_o    = min_q;
  assign period_o = period_q;
  assign kick_o   = kick_q;
  assign busy_o   = busy_q;

endmodule
